// File: rtl/inv_cipher_iter_if.sv
// inv_cipher_iter_if: ciphertext-in / plaintext-out handshake plus round-key lookup bus
//   in_valid/in_ready/ct_in      ciphertext state handshake (producer -> block)
//   rk_idx/rk_in                 combinational round-key store lookup
//   out_valid/out_ready/pt_out   plaintext state handshake (block -> consumer)
//   busy                         block is working on or holding a result
interface inv_cipher_iter_if;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] rk_idx;
  logic [3:0][3:0][7:0] ct_in, rk_in, pt_out;
  modport slave (
    input in_valid, ct_in, rk_in, out_ready,
    output in_ready, rk_idx, out_valid, pt_out, busy
  );
  modport master (
    output in_valid, ct_in, rk_in, out_ready,
    input in_ready, rk_idx, out_valid, pt_out, busy
  );
endinterface

// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter: iterative AES inverse cipher, one round per clock
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   slave side of inv_cipher_iter_if (ct_in handshake, rk_idx/rk_in lookup,
//         pt_out handshake, busy); states are [row][col] bytes
module inv_cipher_iter #(
  parameter int NROUNDS = 10
) (
  input logic clk,
  input logic rst,
  inv_cipher_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  fsm_t r_fsm;
  logic [3:0] r_round;
  logic r_out_valid;
  logic [3:0][3:0][7:0] r_state, r_pt, w_sub, w_ark, w_mix;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // constant k selects which of b, 2b, 4b, 8b are summed, so each call folds to an xor network
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (k[3] ? b8 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction
  // InvShiftRows folded into the S-box lookup: byte (r,c) comes from column (c-r) mod 4
  always_comb begin
    w_sub = '0;
    w_mix = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        w_sub[2'(r)][2'(c)] = INV_SBOX[r_state[2'(r)][2'(c - r)]];
    w_ark = w_sub ^ bus.rk_in;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        w_mix[2'(r)][2'(c)] = gm(w_ark[2'(r)][2'(c)], 4'he) ^ gm(w_ark[2'(r + 1)][2'(c)], 4'hb)
                            ^ gm(w_ark[2'(r + 2)][2'(c)], 4'hd) ^ gm(w_ark[2'(r + 3)][2'(c)], 4'h9);
  end
  assign bus.in_ready = rst && r_fsm == IDLE;
  assign bus.busy = r_fsm != IDLE;
  assign bus.rk_idx = r_fsm == IDLE ? 4'(NROUNDS) : r_fsm == ROUND ? r_round : 4'd0;
  assign bus.out_valid = r_out_valid;
  assign bus.pt_out = r_pt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_fsm <= IDLE;
      r_state <= '0;
      r_round <= '0;
      r_out_valid <= 1'b0;
      r_pt <= '0;
    end else
      case (r_fsm)
        IDLE: if (bus.in_valid) begin
          r_state <= bus.ct_in ^ bus.rk_in;
          r_round <= 4'(NROUNDS - 1);
          r_fsm <= ROUND;
        end
        ROUND: begin
          r_state <= w_mix;
          if (r_round == 4'd1) r_fsm <= FINAL;
          else r_round <= r_round - 4'd1;
        end
        FINAL: begin
          r_pt <= w_ark;
          r_out_valid <= 1'b1;
          r_fsm <= DONE;
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_fsm <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_inv_cipher_iter.sv
// tb_inv_cipher_iter: directed checks of inv_cipher_iter against FIPS-197 and a bench-side model
module tb_inv_cipher_iter;
  typedef logic [3:0][3:0][7:0] st_t;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ST0 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] CT2 = 128'h00112233445566778899aabbccddeeff;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0, n_fail = 0;
  logic [7:0] fsb [0:255];
  logic [7:0] isb [0:255];
  logic [127:0] rkh [0:15];
  logic [31:0] w [0:43];
  inv_cipher_iter_if bus ();
  inv_cipher_iter #(.NROUNDS(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic st_t to_st(input logic [127:0] h);
    st_t s;
    for (int i = 0; i < 16; i++) begin
      s[2'(i)][2'(i / 4)] = h[127:120];
      h = h << 8;
    end
    return s;
  endfunction
  function automatic logic [127:0] to_hex(input st_t s);
    logic [127:0] h = '0;
    for (int i = 0; i < 16; i++) h = {h[119:0], s[2'(i)][2'(i / 4)]};
    return h;
  endfunction
  always_comb bus.rk_in = to_st(rkh[bus.rk_idx]);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      b = b >> 1;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic st_t m_sub(input st_t s);
    st_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[2'(r)][2'(c)] = isb[s[2'(r)][2'(c - r)]];
    return o;
  endfunction
  function automatic st_t m_imc(input st_t s);
    st_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[2'(r)][2'(c)] = gmul(s[2'(r)][2'(c)], 8'h0e) ^ gmul(s[2'(r + 1)][2'(c)], 8'h0b)
                        ^ gmul(s[2'(r + 2)][2'(c)], 8'h0d) ^ gmul(s[2'(r + 3)][2'(c)], 8'h09);
    return o;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] ct);
    st_t s = to_st(ct) ^ to_st(rkh[10]);
    for (int n = 9; n >= 1; n--) s = m_imc(m_sub(s) ^ to_st(rkh[n]));
    return to_hex(m_sub(s) ^ to_st(rkh[0]));
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_one(input logic [127:0] ct, output logic [127:0] pt, output int lat);
    bus.ct_in = to_st(ct);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    lat = -1;
    pt = '0;
    for (int k = 1; k <= 30; k++) begin
      tick;
      if (bus.out_valid) begin
        lat = k;
        pt = to_hex(bus.pt_out);
        break;
      end
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [127:0] pt, res [0:1];
    logic [31:0] t;
    logic [7:0] rc;
    int lat, n_acc, n_res, acc_cyc [0:1];
    logic acc;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'd1) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      fsb[x] = s;
      isb[s] = 8'(x);
    end
    {w[0], w[1], w[2], w[3]} = KEY;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {fsb[t[23:16]], fsb[t[15:8]], fsb[t[7:0]], fsb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int j = 0; j < 16; j++) rkh[j] = j < 11 ? {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]} : '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.ct_in = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset pt_out", bus.pt_out, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset in_ready", bus.in_ready, 0);
    repeat (2) tick;
    rst = 1'b1;
    #1;
    chk("in_ready after reset", bus.in_ready, 1);
    bus.ct_in = to_st(CT);
    bus.in_valid = 1'b1;
    #1;
    chk("rk_idx idle", bus.rk_idx, 10);
    tick;
    bus.in_valid = 1'b0;
    chk("state after accept", to_hex(dut.r_state), ST0);
    chk("busy in round", bus.busy, 1);
    chk("in_ready in round", bus.in_ready, 0);
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("rk_idx edge %0d", j), bus.rk_idx, 128'(9 - j));
      chk($sformatf("out_valid early edge %0d", j), bus.out_valid, 0);
      tick;
    end
    chk("out_valid at edge 10", bus.out_valid, 1);
    chk("fips pt", to_hex(bus.pt_out), PT);
    bus.ct_in = to_st(CT2);
    bus.in_valid = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick;
      chk($sformatf("hold out_valid %0d", j), bus.out_valid, 1);
      chk($sformatf("hold pt %0d", j), to_hex(bus.pt_out), PT);
      chk($sformatf("hold in_ready %0d", j), bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    chk("release out_valid", bus.out_valid, 0);
    chk("release busy", bus.busy, 0);
    chk("release in_ready", bus.in_ready, 1);
    bus.ct_in = to_st(CT);
    bus.in_valid = 1'b1;
    n_acc = 0;
    n_res = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    res[0] = '0;
    res[1] = '0;
    for (int cyc = 0; cyc < 60 && n_res < 2; cyc++) begin
      acc = bus.in_valid & bus.in_ready;
      tick;
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        bus.ct_in = to_st(CT2);
        if (n_acc == 2) bus.in_valid = 1'b0;
      end
      if (bus.out_valid && n_res < 2) begin
        res[n_res] = to_hex(bus.pt_out);
        n_res++;
      end
    end
    tick;
    chk("b2b single-cycle out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    chk("b2b result count", n_res, 2);
    chk("b2b accept spacing", acc_cyc[1] - acc_cyc[0], 12);
    chk("b2b pt 0", res[0], PT);
    chk("b2b pt 1", res[1], model(CT2));
    bus.ct_in = to_st(CT);
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    repeat (4) tick;
    chk("rk_idx at round 5", bus.rk_idx, 5);
    #2 rst = 1'b0;
    #1;
    chk("abort out_valid", bus.out_valid, 0);
    chk("abort busy", bus.busy, 0);
    chk("abort pt_out", bus.pt_out, 0);
    chk("abort rk_idx", bus.rk_idx, 10);
    tick;
    rst = 1'b1;
    #1;
    run_one(CT, pt, lat);
    chk("rerun pt", pt, PT);
    chk("rerun latency", lat, 10);
    for (int j = 0; j < 16; j++) rkh[j] = '0;
    #1;
    run_one(128'h0, pt, lat);
    chk("zero pt", pt, model(128'h0));
    chk("zero latency", lat, 10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
